// File: rtl/quadrilatero_mem_arbiter.sv
// quadrilatero_mem_arbiter: round-robin arbiter sharing one wide OBI-style
// memory request port between NUM_REQ internal requesters. A choice that is
// presented but not granted is locked until granted. Granted requester IDs go
// into an in-order FIFO so each response beat is routed back to its issuer.
module quadrilatero_mem_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned BUS_WIDTH       = 128,  // matches quadrilatero's bus width
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,

  input  logic [NUM_REQ-1:0]                    req_i,
  input  logic [NUM_REQ-1:0]                    we_i,
  input  logic [NUM_REQ-1:0][BUS_WIDTH/8-1:0]   be_i,
  input  logic [NUM_REQ-1:0][31:0]              addr_i,
  input  logic [NUM_REQ-1:0][BUS_WIDTH-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]                    gnt_o,
  output logic [NUM_REQ-1:0]                    rvalid_o,
  output logic [BUS_WIDTH-1:0]                  rdata_o,

  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [BUS_WIDTH/8-1:0]                mem_be_o,
  output logic [31:0]                           mem_addr_o,
  output logic [BUS_WIDTH-1:0]                  mem_wdata_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [BUS_WIDTH-1:0]                  mem_rdata_i,

  output logic                                  err_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Registered state
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];

  // Combinational decisions
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic             lock_drop;
  logic             choice_valid;
  logic [IDX_W-1:0] choice;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             spurious_rsp;
  logic [IDX_W-1:0] head_id;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned pos;
    rr_found = 1'b0;
    rr_idx   = '0;
    pos      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!rr_found && req_i[IDX_W'(pos)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(pos);
      end
    end
  end

  // Final choice: a held lock overrides the round-robin search
  always_comb begin
    lock_drop    = lock_valid_q && !req_i[lock_idx_q];
    choice_valid = rr_found;
    choice       = rr_idx;
    if (lock_valid_q) begin
      choice_valid = !lock_drop;
      choice       = lock_idx_q;
    end
  end

  // Handshake qualifiers
  always_comb begin
    fifo_full    = (count_q == CNT_W'(MAX_OUTSTANDING));
    push         = choice_valid && !fifo_full && mem_gnt_i;
    pop          = mem_rvalid_i && (count_q != '0);
    spurious_rsp = mem_rvalid_i && (count_q == '0);
    head_id      = fifo_q[rptr_q];
  end

  // Downstream request mux and upstream grant/response steering
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    rdata_o     = mem_rdata_i;
    if (choice_valid) begin
      mem_req_o   = !fifo_full;
      mem_we_o    = we_i[choice];
      mem_be_o    = be_i[choice];
      mem_addr_o  = addr_i[choice];
      mem_wdata_o = wdata_i[choice];
    end
    if (push) gnt_o[choice] = 1'b1;
    if (pop)  rvalid_o[head_id] = 1'b1;
  end

  assign err_o = err_q;

  // Next-state for pointer, lock, FIFO bookkeeping and error flag
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    err_d        = err_q;

    if (spurious_rsp || lock_drop) err_d = 1'b1;

    // Lock: released on grant or protocol violation, taken on a stalled request
    if (lock_drop || push) begin
      lock_valid_d = 1'b0;
    end else if (choice_valid && !fifo_full) begin
      lock_valid_d = 1'b1;
      lock_idx_d   = choice;
    end

    if (push) begin
      rr_ptr_d = (choice == IDX_W'(NUM_REQ - 1)) ? '0 : choice + IDX_W'(1);
      wptr_d   = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PTR_W'(1);
    end

    if (pop) begin
      rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // ID FIFO storage; contents are only meaningful below count_q
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= choice;
  end

endmodule

// File: tb/tb_quadrilatero_mem_arbiter.sv
// Bench for quadrilatero_mem_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the arbiter.
module tb_quadrilatero_mem_arbiter;

  localparam int unsigned N    = 3;
  localparam int unsigned BW   = 32;
  localparam int unsigned BEW  = BW / 8;
  localparam int unsigned MAXO = 4;

  logic                        clk = 1'b0;
  logic                        rst_ni;
  logic [N-1:0]                req_i, we_i;
  logic [N-1:0][BEW-1:0]       be_i;
  logic [N-1:0][31:0]          addr_i;
  logic [N-1:0][BW-1:0]        wdata_i;
  logic [N-1:0]                gnt_o, rvalid_o;
  logic [BW-1:0]               rdata_o;
  logic                        mem_req_o, mem_we_o;
  logic [BEW-1:0]              mem_be_o;
  logic [31:0]                 mem_addr_o;
  logic [BW-1:0]               mem_wdata_o;
  logic                        mem_gnt_i, mem_rvalid_i;
  logic [BW-1:0]               mem_rdata_i;
  logic                        err_o;

  quadrilatero_mem_arbiter #(
    .NUM_REQ(N), .BUS_WIDTH(BW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding IDs in issue order, next-priority index, held lock (-1 = none)
  int m_q[$];
  int m_rr   = 0;
  int m_lock = -1;
  bit m_err  = 1'b0;

  // Outputs sampled in the most recent step
  logic [N-1:0]  s_gnt, s_rvalid;
  logic          s_req, s_err;
  logic [31:0]   s_addr;
  logic [BW-1:0] s_rdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, check settled outputs, advance model
  task automatic step(input logic [N-1:0] req, input bit gnt, input bit rv,
                      input logic [BW-1:0] rdata, input bit rst_low, input bit rnd_payload);
    int            ch;
    int            pos;
    bit            e_req;
    bit            e_push;
    logic [N-1:0]  e_gnt, e_rv;
    logic [1:0]    chi;
    logic [31:0]   e_addr;
    logic          e_we;
    logic [BEW-1:0] e_be;
    logic [BW-1:0] e_wdata;

    @(negedge clk);
    rst_ni       = !rst_low;
    req_i        = req;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rdata;
    for (int i = 0; i < int'(N); i++) begin
      we_i[i]    = 1'($urandom);
      be_i[i]    = BEW'($urandom);
      wdata_i[i] = BW'($urandom);
      addr_i[i]  = rnd_payload ? 32'($urandom) : 32'(32'h1000 * (i + 1));
    end
    #1;

    ch = -1;
    if (m_lock >= 0) begin
      if (req[m_lock]) ch = m_lock;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        pos = (m_rr + k) % int'(N);
        if (ch < 0 && req[pos]) ch = pos;
      end
    end
    e_req   = (ch >= 0) && (m_q.size() < int'(MAXO));
    e_push  = e_req && gnt;
    e_gnt   = e_push ? N'(1) << ch : '0;
    e_rv    = (rv && m_q.size() > 0) ? N'(1) << m_q[0] : '0;
    chi     = (ch >= 0) ? 2'(ch) : 2'd0;
    e_addr  = (ch >= 0) ? addr_i[chi]  : '0;
    e_we    = (ch >= 0) ? we_i[chi]    : 1'b0;
    e_be    = (ch >= 0) ? be_i[chi]    : '0;
    e_wdata = (ch >= 0) ? wdata_i[chi] : '0;

    check_eq("mem_req",    64'(mem_req_o),        64'(e_req));
    check_eq("gnt",        64'(gnt_o),            64'(e_gnt));
    check_eq("rvalid",     64'(rvalid_o),         64'(e_rv));
    check_eq("rdata",      64'(rdata_o),          64'(rdata));
    check_eq("mem_addr",   64'(mem_addr_o),       64'(e_addr));
    check_eq("mem_we",     64'(mem_we_o),         64'(e_we));
    check_eq("mem_be",     64'(mem_be_o),         64'(e_be));
    check_eq("mem_wdata",  64'(mem_wdata_o),      64'(e_wdata));
    check_eq("err",        64'(err_o),            64'(m_err));
    check_eq("count",      64'(dut.count_q),      64'(m_q.size()));
    check_eq("rr_ptr",     64'(dut.rr_ptr_q),     64'(m_rr));
    check_eq("lock_valid", 64'(dut.lock_valid_q), 64'(m_lock >= 0));

    s_gnt = gnt_o; s_rvalid = rvalid_o; s_req = mem_req_o;
    s_err = err_o; s_addr = mem_addr_o; s_rdata = rdata_o;

    if (rst_low) begin
      m_q.delete();
      m_rr   = 0;
      m_lock = -1;
      m_err  = 1'b0;
    end else begin
      if (rv && m_q.size() == 0) m_err = 1'b1;
      if (m_lock >= 0 && !req[m_lock]) begin
        m_err  = 1'b1;
        m_lock = -1;
      end else if (e_push) begin
        m_lock = -1;
      end else if (e_req) begin
        m_lock = ch;
      end
      if (e_rv != '0) void'(m_q.pop_front());
      if (e_push) begin
        m_q.push_back(ch);
        m_rr = (ch + 1) % int'(N);
      end
    end
  endtask

  initial begin
    logic [N-1:0] req;
    bit           rv;

    rst_ni = 1'b0; req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);

    // Reset state, idle inputs
    step(3'b000, 0, 0, '0, 0, 0);
    check_eq("reset_req", 64'(s_req), 64'd0);
    check_eq("reset_gnt", 64'(s_gnt), 64'd0);
    check_eq("reset_err", 64'(s_err), 64'd0);

    // Rotation with responses one cycle behind each grant
    for (int k = 0; k < 8; k++) begin
      step(3'b011, 1, k > 0, BW'(k), 0, 0);
      check_eq("rot_gnt", 64'(s_gnt), (k % 2 == 1) ? 64'h2 : 64'h1);
      if (k > 0) check_eq("rot_rvalid", 64'(s_rvalid), (k % 2 == 1) ? 64'h1 : 64'h2);
    end
    step(3'b000, 0, 1, '0, 0, 0);

    // Lock stability: req0 held while req1 waits
    for (int k = 0; k < 3; k++) begin
      step(3'b011, 0, 0, '0, 0, 0);
      check_eq("lock_addr", 64'(s_addr), 64'h1000);
    end
    step(3'b011, 1, 0, '0, 0, 0);
    check_eq("lock_addr_gnt", 64'(s_addr), 64'h1000);
    check_eq("lock_gnt0", 64'(s_gnt), 64'h1);
    step(3'b011, 1, 0, '0, 0, 0);
    check_eq("lock_gnt1", 64'(s_gnt), 64'h2);
    repeat (2) step(3'b000, 0, 1, '0, 0, 0);

    // Outstanding limit
    for (int k = 0; k < 4; k++) begin
      step(3'b001, 1, 0, '0, 0, 0);
      check_eq("lim_gnt", 64'(s_gnt), 64'h1);
    end
    step(3'b001, 1, 0, '0, 0, 0);
    check_eq("lim_full_req", 64'(s_req), 64'd0);
    step(3'b001, 1, 1, '0, 0, 0);
    check_eq("lim_pop_req", 64'(s_req), 64'd0);
    step(3'b001, 0, 0, '0, 0, 0);
    check_eq("lim_after_pop_req", 64'(s_req), 64'd1);
    step(3'b001, 1, 0, '0, 0, 0);
    repeat (4) step(3'b000, 0, 1, '0, 0, 0);

    // Response routing: grant order req1, req0, req1 with push+pop at count 2
    step(3'b010, 1, 0, '0, 0, 0);
    step(3'b001, 1, 0, '0, 0, 0);
    step(3'b010, 1, 1, BW'(32'hA), 0, 0);
    check_eq("route_rv_a", 64'(s_rvalid), 64'h2);
    check_eq("route_rd_a", 64'(s_rdata), 64'hA);
    step(3'b000, 0, 1, BW'(32'hB), 0, 0);
    check_eq("route_rv_b", 64'(s_rvalid), 64'h1);
    step(3'b000, 0, 1, BW'(32'hC), 0, 0);
    check_eq("route_rv_c", 64'(s_rvalid), 64'h2);
    check_eq("route_rd_c", 64'(s_rdata), 64'hC);

    // Spurious response sets a sticky error cleared only by reset
    step(3'b000, 0, 1, '0, 0, 0);
    check_eq("err_rvalid", 64'(s_rvalid), 64'd0);
    step(3'b000, 0, 0, '0, 0, 0);
    check_eq("err_set", 64'(s_err), 64'd1);
    step(3'b000, 0, 0, '0, 0, 0);
    check_eq("err_sticky", 64'(s_err), 64'd1);
    step(3'b000, 0, 0, '0, 1, 0);
    step(3'b000, 0, 0, '0, 0, 0);
    check_eq("err_cleared", 64'(s_err), 64'd0);

    // Lock dropped by its requester: request falls, error set
    step(3'b001, 0, 0, '0, 0, 0);
    step(3'b010, 0, 0, '0, 0, 0);
    check_eq("drop_req", 64'(s_req), 64'd0);
    step(3'b000, 0, 0, '0, 0, 0);
    check_eq("drop_err", 64'(s_err), 64'd1);
    step(3'b000, 0, 0, '0, 1, 0);

    // Reset mid-burst with count 3 and a lock held
    repeat (3) step(3'b111, 1, 0, '0, 0, 0);
    step(3'b011, 0, 0, '0, 0, 0);
    step(3'b011, 0, 0, '0, 1, 0);
    step(3'b100, 0, 0, '0, 0, 0);
    check_eq("rst_count", 64'(dut.count_q), 64'd0);
    check_eq("rst_rr", 64'(dut.rr_ptr_q), 64'd0);
    check_eq("rst_req_comb", 64'(s_req), 64'd1);
    step(3'b000, 0, 0, '0, 1, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req = N'($urandom);
      if (m_lock >= 0) req[m_lock] = 1'b1;
      rv = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      step(req, $urandom_range(0, 99) < 60, rv, BW'($urandom), $urandom_range(0, 299) == 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quadrilatero_mem_arbiter.md
# quadrilatero_mem_arbiter

Round-robin arbiter that shares quadrilatero's single wide memory request port between `NUM_REQ` internal requesters (e.g. load unit, store unit, prefetcher). It sits between those requesters and `quadrilatero_to_obi`. It forwards one OBI-style request at a time and holds a locked choice until the request is granted. It tracks outstanding transactions in an in-order ID FIFO so that each `mem_rvalid_i` beat is routed to the requester that issued it.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `BUS_WIDTH`, default `quadrilatero_pkg::BUS_WIDTH`: data width in bits, a multiple of 8.
- `MAX_OUTSTANDING`, default 4: depth of the ID FIFO, i.e. the maximum number of granted transactions still awaiting a response. Range 1..16.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, synchronous, active-low.
- `req_i`  in  `NUM_REQ`  per-requester request.
- `we_i`  in  `NUM_REQ`  per-requester write enable.
- `be_i`  in  `NUM_REQ`×`BUS_WIDTH/8`  per-requester byte enables.
- `addr_i`  in  `NUM_REQ`×32  per-requester address.
- `wdata_i`  in  `NUM_REQ`×`BUS_WIDTH`  per-requester write data.
- `gnt_o`  out  `NUM_REQ`  per-requester grant; one-hot or zero.
- `rvalid_o`  out  `NUM_REQ`  per-requester response valid; one-hot or zero.
- `rdata_o`  out  `BUS_WIDTH`  response data, broadcast to all requesters.
- `mem_req_o`  out  1  downstream request.
- `mem_we_o`  out  1  downstream write enable.
- `mem_be_o`  out  `BUS_WIDTH/8`  downstream byte enables.
- `mem_addr_o`  out  32  downstream address.
- `mem_wdata_o`  out  `BUS_WIDTH`  downstream write data.
- `mem_gnt_i`  in  1  downstream grant.
- `mem_rvalid_i`  in  1  downstream response valid; asserted for both reads and writes.
- `mem_rdata_i`  in  `BUS_WIDTH`  downstream response data.
- `err_o`  out  1  sticky protocol error flag.

## Operation
- **Registered state:**
  - `rr_ptr`: next-priority index.
  - `lock_valid` / `lock_idx`: held choice.
  - ID FIFO of `MAX_OUTSTANDING` entries, each `$clog2(NUM_REQ)` bits wide, with read and write pointers.
  - `count`: occupancy, 0..`MAX_OUTSTANDING`.
  - `err_o`.
- **Choice:**
  - If `lock_valid`, the chosen index is `lock_idx`.
  - Otherwise it is the first index `i` with `req_i[i]`=1, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- **Request forwarding:**
  - `mem_req_o` = (a choice exists) AND (`count` < `MAX_OUTSTANDING`).
  - `mem_we/be/addr/wdata_o` are muxed from the chosen index. When there is no choice they are driven to 0.
- **Grant:** `gnt_o[choice]` = `mem_req_o` AND `mem_gnt_i`. All other `gnt_o` bits are 0.
- **Lock:**
  - If `mem_req_o`=1 and `mem_gnt_i`=0: set `lock_valid`=1 and `lock_idx`=choice.
  - On grant: clear `lock_valid`.
  - A locked requester is assumed to hold `req_i` per OBI. If its `req_i` drops while locked, the lock is cleared, `mem_req_o` falls that cycle, and `err_o` is set.
- **On grant:**
  - Push the choice into the ID FIFO.
  - Set `rr_ptr` = (choice+1) mod `NUM_REQ`.
- **On `mem_rvalid_i`:**
  - If `count`>0: `rvalid_o[fifo_head]`=1, then pop.
  - If `count`=0: set `err_o`. `rvalid_o` stays all 0 and `count` is unchanged.
  - `rdata_o` = `mem_rdata_i` always.
- **Simultaneous push and pop:** both occur and `count` is unchanged. This is legal at any occupancy below full; at full no push is possible.
- **Full FIFO:** when `count`=`MAX_OUTSTANDING`, `mem_req_o`=0 and any existing lock is held. A pop that cycle makes a request possible in the next cycle.
- **Pointers:** FIFO pointers wrap modulo `MAX_OUTSTANDING`. Non-power-of-2 depths are supported.
- **Clearing `err_o`:** reset only.

## Timing
- **Reset values** (applied synchronously on the clock edge while `rst_ni`=0):
  - `rr_ptr`=0, `lock_valid`=0, `count`=0, FIFO pointers=0, `err_o`=0.
  - Consequently `mem_req_o`=0, `gnt_o`=0 and `rvalid_o`=0 out of reset, absent input activity.
- **Reset mid-transaction:** outstanding IDs are discarded. Responses arriving after reset hit `count`=0 and set `err_o`; the bench must not issue them.
- **Combinational paths** (zero added latency):
  - `req_i` → `mem_req_o`
  - `mem_gnt_i` → `gnt_o`
  - `mem_rvalid_i` → `rvalid_o` and `rdata_o`
  - There is no combinational path from `mem_gnt_i` to `mem_req_o`.
- **Registered update:** `rr_ptr`, lock, FIFO and `count` update on the rising edge after the handshake.
- **Throughput:** one grant per cycle when `mem_gnt_i`=1 continuously and the FIFO is not full. The earliest response for a grant in cycle N is in cycle N+1.
- **Fairness:** with all requesters continuously requesting and `mem_gnt_i`=1, grants rotate 0,1,…,`NUM_REQ`-1,0. No requester waits more than `NUM_REQ`-1 grants.

## Test plan
- **Rotation:** `NUM_REQ`=2, both `req_i`=1, `mem_gnt_i`=1, `mem_rvalid_i` one cycle after each grant → `gnt_o` alternates 01,10,01,10; `rvalid_o` follows the same order one cycle later.
- **Lock stability:** `req_i`=11, `mem_gnt_i`=0 for 3 cycles, then 1 → `mem_addr_o` stays at req0's address (0x1000) for all 4 cycles even though req1 (0x2000) is pending; then req1 is granted next.
- **Outstanding limit:** `MAX_OUTSTANDING`=4, `mem_gnt_i`=1, no responses → exactly 4 grants, then `mem_req_o`=0. One `mem_rvalid_i` → `mem_req_o`=1 in the following cycle.
- **Response routing:** grant order req1, req0, req1 with rdata values 0xA, 0xB, 0xC → `rvalid_o` = 10, 01, 10 with matching `rdata_o`. Also check a push and pop in the same cycle at `count`=2 leaves `count`=2.
- **Error detection:** `mem_rvalid_i` with `count`=0 → `err_o` rises the next cycle and stays high; `rvalid_o`=0. Assert `rst_ni`=0 for one edge → `err_o`=0.
- **Synchronous reset:** drive `rst_ni`=0 mid-burst with `count`=3 → after the edge, `count`=0, `rr_ptr`=0 and `lock_valid`=0. `mem_req_o` tracks `req_i` only through the combinational choice.
